// File: rtl/seq_divider32.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock,
// start/busy/done handshake, results held until the next completion.
module seq_divider32 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             DZ,
    output logic             ZF
);

    localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    // Partial remainder is always < B, so its top (WIDTH+1'th) bit is
    // never set between iterations and only needs to exist in the trial.
    logic [WIDTH-1:0]   p_q, p_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH-1:0]   r_q, r_d;
    logic               dz_q, dz_d;
    logic               zf_q, zf_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [WIDTH:0]     p_sh;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   rem_nxt;
    logic [WIDTH-1:0]   dvd_nxt;

    // One restoring iteration: shift {P, dividend}, trial-subtract B, keep or restore.
    always_comb begin
        p_sh    = {p_q, dvd_q[WIDTH-1]};
        trial   = p_sh - {1'b0, b_q};
        rem_nxt = trial[WIDTH] ? p_sh[WIDTH-1:0] : trial[WIDTH-1:0];
        dvd_nxt = {dvd_q[WIDTH-2:0], ~trial[WIDTH]};
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        dvd_d   = dvd_q;
        b_d     = b_q;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;
        zf_d    = zf_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (B == '0) begin
                        state_d = S_DONE;
                        q_d     = '1;
                        r_d     = A;
                        dz_d    = 1'b1;
                        zf_d    = 1'b0;
                    end else begin
                        state_d = S_CALC;
                        dvd_d   = A;
                        b_d     = B;
                        p_d     = '0;
                        cnt_d   = '0;
                    end
                end
            end
            S_CALC: begin
                p_d   = rem_nxt;
                dvd_d = dvd_nxt;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_DONE;
                    q_d     = dvd_nxt;
                    r_d     = rem_nxt;
                    dz_d    = 1'b0;
                    zf_d    = (dvd_nxt == '0);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
            dvd_q   <= '0;
            b_q     <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
            zf_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            dvd_q   <= dvd_d;
            b_q     <= b_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
            zf_q    <= zf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign Q    = q_q;
    assign R    = r_q;
    assign DZ   = dz_q;
    assign ZF   = zf_q;

endmodule

// File: tb/tb_seq_divider32.sv
// Self-checking bench for seq_divider32: vector table, corner sequences
// and random back-to-back operations, checked through a scoreboard queue.
module tb_seq_divider32;

    localparam int unsigned W = 32;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         zf;

    seq_divider32 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (a),
        .B     (b),
        .busy  (busy),
        .done  (done),
        .Q     (q),
        .R     (r),
        .DZ    (dz),
        .ZF    (zf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         zf;
    } vec_t;

    vec_t sb[$];
    int   checks;
    int   failures;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference result for one operation.
    function automatic vec_t model(input logic [W-1:0] ma, input logic [W-1:0] mb);
        vec_t v;
        v.a = ma;
        v.b = mb;
        if (mb == '0) begin
            v.q  = '1;
            v.r  = ma;
            v.dz = 1'b1;
            v.zf = 1'b0;
        end else begin
            v.q  = ma / mb;
            v.r  = ma % mb;
            v.dz = 1'b0;
            v.zf = (v.q == '0);
        end
        return v;
    endfunction

    // Drive a one-cycle start at a negedge, record the expectation.
    task automatic do_start(input vec_t v);
        a     = v.a;
        b     = v.b;
        start = 1'b1;
        sb.push_back(v);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'(1));
    endtask

    // Wait (bounded) for done, pop the scoreboard and compare.
    task automatic wait_done(input int exp_lat);
        int   lat;
        vec_t e;
        lat = 0;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!done) begin
            chk("done_timeout", 64'(done), 64'(1));
            if (sb.size() != 0) void'(sb.pop_front());
            return;
        end
        if (exp_lat >= 0) chk("latency", 64'(lat), 64'(exp_lat));
        if (sb.size() == 0) begin
            chk("unexpected_done", 64'(sb.size()), 64'(1));
        end else begin
            e = sb.pop_front();
            chk("Q", 64'(q), 64'(e.q));
            chk("R", 64'(r), 64'(e.r));
            chk("DZ", 64'(dz), 64'(e.dz));
            chk("ZF", 64'(zf), 64'(e.zf));
            if (e.b != '0) begin
                chk("inv_qb_plus_r", ({32'b0, q} * {32'b0, e.b}) + {32'b0, r}, {32'b0, e.a});
                chk("inv_r_lt_b", 64'(r < e.b), 64'(1));
            end
        end
        @(negedge clk);
        chk("done_one_cycle", 64'(done), 64'(0));
        chk("idle_after_done", 64'(busy), 64'(0));
    endtask

    vec_t tbl[11];

    initial begin
        checks   = 0;
        failures = 0;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        rst_n    = 1'b0;

        tbl[0]  = '{32'd100,        32'd7,          32'd14,         32'd2,     1'b0, 1'b0};
        tbl[1]  = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,     1'b0, 1'b0};
        tbl[2]  = '{32'h8000_0000,  32'h8000_0000,  32'd1,          32'd0,     1'b0, 1'b0};
        tbl[3]  = '{32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,     1'b1, 1'b0};
        tbl[4]  = '{32'd3,          32'd10,         32'd0,          32'd3,     1'b0, 1'b1};
        tbl[5]  = '{32'd0,          32'd5,          32'd0,          32'd0,     1'b0, 1'b1};
        tbl[6]  = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,     1'b0, 1'b0};
        tbl[7]  = '{32'h1234_5678,  32'h0001_0000,  32'h0000_1234,  32'h5678,  1'b0, 1'b0};
        tbl[8]  = '{32'd0,          32'd0,          32'hFFFF_FFFF,  32'd0,     1'b1, 1'b0};
        tbl[9]  = '{32'd7,          32'd2,          32'd3,          32'd1,     1'b0, 1'b0};
        tbl[10] = '{32'hFFFF_FFFF,  32'd2,          32'h7FFF_FFFF,  32'd1,     1'b0, 1'b0};

        // Reset values.
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_Q", 64'(q), 64'(0));
        chk("rst_R", 64'(r), 64'(0));
        chk("rst_DZ", 64'(dz), 64'(0));
        chk("rst_ZF", 64'(zf), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Vector table; divide-by-zero entries complete immediately and
        // the following entry shows DZ cleared again.
        for (int i = 0; i < 11; i++) begin
            do_start(tbl[i]);
            wait_done(tbl[i].b == '0 ? 0 : 32);
        end

        // Start pulsed mid-calculation must be ignored.
        do_start('{32'd3, 32'd10, 32'd0, 32'd3, 1'b0, 1'b1});
        repeat (4) @(negedge clk);
        a     = 32'd9;
        b     = 32'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(27);
        begin
            int extra;
            extra = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (done) extra++;
            end
            chk("ignored_start_no_done", 64'(extra), 64'(0));
            chk("hold_Q_idle", 64'(q), 64'(0));
            chk("hold_R_idle", 64'(r), 64'(3));
        end

        // Leave a nonzero result, then reset mid-calculation.
        do_start(model(32'd100, 32'd7));
        wait_done(32);
        do_start(model(32'd1000, 32'd3));
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_done", 64'(done), 64'(0));
        chk("midrst_Q", 64'(q), 64'(0));
        chk("midrst_R", 64'(r), 64'(0));
        sb.delete();
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                if (done) seen++;
            end
            rst_n = 1'b1;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (done) seen++;
            end
            chk("midrst_no_done", 64'(seen), 64'(0));
        end
        do_start('{32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 1'b0});
        wait_done(32);

        // Random back-to-back operations, restart in the first IDLE cycle.
        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = $urandom;
            case (i % 4)
                0:       rb = $urandom;
                1:       rb = W'($urandom_range(1, 255));
                2:       rb = $urandom >> $urandom_range(0, 31);
                default: rb = W'($urandom_range(1, 65535));
            endcase
            if (rb == '0) rb = W'(1);
            do_start(model(ra, rb));
            wait_done(32);
        end
        chk("sb_drained", 64'(sb.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
